// File: rtl/pipeline_hazard_controller.sv
// Central hazard/sequencing controller for the 5-stage pipeline: load-use stalls,
// branch flushes, memory freezes, halt drain, and saturating stall/flush counters.
module pipeline_hazard_controller #(
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             ifid_uses_rs1,
  input  logic             ifid_uses_rs2,
  input  logic [4:0]       idex_rd,
  input  logic             idex_mem_read,
  input  logic             pc_src,
  input  logic             mem_busy,
  input  logic             halt_req,
  output logic             PC_write,
  output logic             ifid_write,
  output logic             ctrl_hazard,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic             pipe_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned DW = $clog2(DRAIN_CYCLES) + 1;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] drain_cnt, drain_nxt;
  logic          lu;
  logic          stall_inc, flush_inc;

  assign lu = idex_mem_read && (idex_rd != 5'd0) &&
              ((ifid_uses_rs1 && (ifid_rs1 == idex_rd)) ||
               (ifid_uses_rs2 && (ifid_rs2 == idex_rd)));

  always_comb begin
    state_nxt   = state;
    drain_nxt   = drain_cnt;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    PC_write    = 1'b0;
    ifid_write  = 1'b0;
    ctrl_hazard = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    pipe_en     = 1'b0;
    halted      = 1'b0;
    if (rst) begin
      ctrl_hazard = 1'b1;
    end else begin
      unique case (state)
        HALTED: begin
          ctrl_hazard = 1'b1;
          halted      = 1'b1;
        end
        default: begin
          if (mem_busy) begin
            stall_inc = 1'b1;
          end else if (pc_src) begin
            // A taken branch also squashes a younger halting instruction mid-drain.
            flush_ifid  = 1'b1;
            flush_idex  = 1'b1;
            flush_exmem = 1'b1;
            PC_write    = 1'b1;
            ifid_write  = 1'b1;
            pipe_en     = 1'b1;
            flush_inc   = 1'b1;
            state_nxt   = RUN;
            drain_nxt   = '0;
          end else if (state == DRAIN) begin
            ctrl_hazard = 1'b1;
            pipe_en     = 1'b1;
            if (drain_cnt == '0) state_nxt = HALTED;
            else                 drain_nxt = drain_cnt - 1'b1;
          end else if (halt_req) begin
            ctrl_hazard = 1'b1;
            pipe_en     = 1'b1;
            state_nxt   = DRAIN;
            drain_nxt   = DW'(DRAIN_CYCLES - 1);
          end else if (lu) begin
            ctrl_hazard = 1'b1;
            pipe_en     = 1'b1;
            stall_inc   = 1'b1;
          end else begin
            PC_write   = 1'b1;
            ifid_write = 1'b1;
            pipe_en    = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      drain_cnt   <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
      if (stall_inc && (stall_count != '1)) stall_count <= stall_count + 1'b1;
      if (flush_inc && (flush_count != '1)) flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed-vector bench for pipeline_hazard_controller with a behavioural reference
// model checked every cycle, plus literal expectations at key points.
module tb_pipeline_hazard_controller;

  localparam int unsigned DC = 4;
  localparam int unsigned CW = 4;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4:0]    ifid_rs1 = '0, ifid_rs2 = '0, idex_rd = '0;
  logic          ifid_uses_rs1 = 1'b0, ifid_uses_rs2 = 1'b0, idex_mem_read = 1'b0;
  logic          pc_src = 1'b0, mem_busy = 1'b0, halt_req = 1'b0;
  logic          PC_write, ifid_write, ctrl_hazard, flush_ifid, flush_idex, flush_exmem;
  logic          pipe_en, halted;
  logic [CW-1:0] stall_count, flush_count;

  int tests = 0;
  int fails = 0;

  pipeline_hazard_controller #(.DRAIN_CYCLES(DC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_uses_rs1(ifid_uses_rs1), .ifid_uses_rs2(ifid_uses_rs2),
    .idex_rd(idex_rd), .idex_mem_read(idex_mem_read),
    .pc_src(pc_src), .mem_busy(mem_busy), .halt_req(halt_req),
    .PC_write(PC_write), .ifid_write(ifid_write), .ctrl_hazard(ctrl_hazard),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem),
    .pipe_en(pipe_en), .halted(halted),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: halted flag, drain cycles still owed, event counts.
  bit m_halted;
  int m_drain_left;
  int m_stall, m_flush;

  function automatic bit load_use();
    if (!idex_mem_read || idex_rd == 5'd0) return 1'b0;
    return (ifid_uses_rs1 && ifid_rs1 == idex_rd) || (ifid_uses_rs2 && ifid_rs2 == idex_rd);
  endfunction

  // {PC_write, ifid_write, ctrl_hazard, flush_ifid, flush_idex, flush_exmem, pipe_en, halted}
  function automatic logic [7:0] expected_outs();
    if (rst)                                  return 8'b0010_0000;
    if (m_halted)                             return 8'b0010_0001;
    if (mem_busy)                             return 8'b0000_0000;
    if (pc_src)                               return 8'b1101_1110;
    if (m_drain_left > 0 || halt_req)         return 8'b0010_0010;
    if (load_use())                           return 8'b0010_0010;
    return 8'b1100_0010;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_halted     <= 1'b0;
      m_drain_left <= 0;
      m_stall      <= 0;
      m_flush      <= 0;
    end else if (!m_halted) begin
      if (mem_busy) begin
        m_stall <= (m_stall < CMAX) ? m_stall + 1 : CMAX;
      end else if (pc_src) begin
        m_flush      <= (m_flush < CMAX) ? m_flush + 1 : CMAX;
        m_drain_left <= 0;
      end else if (m_drain_left > 0) begin
        m_drain_left <= m_drain_left - 1;
        if (m_drain_left == 1) m_halted <= 1'b1;
      end else if (halt_req) begin
        m_drain_left <= DC;
      end else if (load_use()) begin
        m_stall <= (m_stall < CMAX) ? m_stall + 1 : CMAX;
      end
    end
  end

  always @(negedge clk) begin
    chk("outs", {PC_write, ifid_write, ctrl_hazard, flush_ifid, flush_idex, flush_exmem,
                 pipe_en, halted}, expected_outs());
    chk("stall_count", stall_count, m_stall);
    chk("flush_count", flush_count, m_flush);
  end

  task automatic idle();
    ifid_rs1 = '0; ifid_rs2 = '0; idex_rd = '0;
    ifid_uses_rs1 = 0; ifid_uses_rs2 = 0; idex_mem_read = 0;
    pc_src = 0; mem_busy = 0; halt_req = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    tick(); tick();
    chk("rst_pc_write", PC_write, 1'b0);
    chk("rst_ctrl_hazard", ctrl_hazard, 1'b1);
    chk("rst_stall", stall_count, 0);
    rst = 1'b0;
    tick();

    // load-use on rs2
    idex_mem_read = 1; idex_rd = 5; ifid_rs2 = 5; ifid_uses_rs2 = 1;
    #1;
    chk("lu_pc_write", PC_write, 1'b0);
    chk("lu_ifid_write", ifid_write, 1'b0);
    chk("lu_ctrl_hazard", ctrl_hazard, 1'b1);
    tick();
    chk("lu_stall", stall_count, 1);
    idle();
    #1;
    chk("post_lu_enables", {PC_write, ifid_write, pipe_en}, 3'b111);
    tick();

    // x0 destination and unused operand never stall
    idex_mem_read = 1; idex_rd = 0; ifid_rs1 = 0; ifid_uses_rs1 = 1;
    #1 chk("x0_pc_write", PC_write, 1'b1);
    tick();
    idle();
    idex_mem_read = 1; idex_rd = 7; ifid_rs2 = 7; ifid_uses_rs2 = 0; ifid_rs1 = 3; ifid_uses_rs1 = 1;
    #1 chk("unused_rs2_pc_write", PC_write, 1'b1);
    tick();
    chk("no_extra_stall", stall_count, 1);
    idle();
    tick();

    // branch flush wins over load-use
    idex_mem_read = 1; idex_rd = 5; ifid_rs2 = 5; ifid_uses_rs2 = 1; pc_src = 1;
    #1;
    chk("br_flushes", {flush_ifid, flush_idex, flush_exmem, PC_write, ctrl_hazard}, 5'b11110);
    tick();
    chk("br_flush_count", flush_count, 1);
    chk("br_stall_count", stall_count, 1);
    idle();
    tick();

    // freeze with pending branch
    pc_src = 1; mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("frz_outs", {pipe_en, PC_write, flush_ifid, flush_exmem}, 4'b0000);
      tick();
    end
    chk("frz_stall", stall_count, 4);
    mem_busy = 0;
    #1 chk("frz_release_flush", flush_ifid, 1'b1);
    tick();
    chk("frz_flush_count", flush_count, 2);
    idle();
    tick();

    // stall counter saturation
    mem_busy = 1;
    for (int i = 0; i < 13; i++) tick();
    chk("stall_saturate", stall_count, CMAX);
    idle();
    tick();

    // halt with one frozen cycle mid-drain
    halt_req = 1;
    #1 chk("halt_entry_ctrl", {ctrl_hazard, PC_write, pipe_en}, 3'b101);
    tick();
    halt_req = 0;
    for (int i = 0; i < 2; i++) begin
      #1 chk("drain_ctrl", {ctrl_hazard, halted}, 2'b10);
      tick();
    end
    mem_busy = 1;
    #1 chk("drain_freeze", {pipe_en, halted}, 2'b00);
    tick();
    mem_busy = 0;
    for (int i = 0; i < 2; i++) begin
      #1 chk("drain_ctrl2", {ctrl_hazard, halted}, 2'b10);
      tick();
    end
    chk("halted", {halted, pipe_en}, 2'b10);
    pc_src = 1; idex_mem_read = 1; idex_rd = 2; ifid_rs1 = 2; ifid_uses_rs1 = 1;
    #1 chk("halted_ignores", {flush_ifid, halted, PC_write}, 3'b010);
    tick();
    chk("halted_flush_count", flush_count, 2);
    idle();

    // asynchronous reset in HALTED
    rst = 1;
    #1;
    chk("arst_halted", {halted, PC_write, ctrl_hazard, pipe_en}, 4'b0010);
    chk("arst_counts", {stall_count, flush_count}, 0);
    tick();
    rst = 0;
    #1 chk("resume_run", PC_write, 1'b1);
    tick();

    // branch during drain cancels halt
    halt_req = 1;
    tick();
    halt_req = 0;
    tick();
    pc_src = 1;
    tick();
    idle();
    for (int i = 0; i < 6; i++) tick();
    chk("drain_cancel", {halted, PC_write}, 2'b01);

    // asynchronous reset mid-drain
    halt_req = 1;
    tick();
    halt_req = 0;
    tick();
    #2 rst = 1;
    #1 chk("arst_drain", {halted, PC_write, ctrl_hazard}, 3'b001);
    chk("arst_drain_counts", {stall_count, flush_count}, 0);
    tick();
    rst = 0;
    for (int i = 0; i < 6; i++) tick();
    chk("post_drain_reset_run", {halted, PC_write}, 2'b01);

    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central sequencing controller for the 5-stage pipeline.
- Detects load-use hazards between ID and EX, and flushes younger stages on a taken branch resolved at the EX/MEM boundary.
- Freezes the whole pipeline while data memory is busy, and drains/halts the core on an ecall/ebreak decoded in ID.
- Drives PC_write, ifid_write, ctrl_hazard, per-register flush lines and a global pipe enable; keeps saturating stall/flush performance counters.

Parameters:
- DRAIN_CYCLES, 4, cycles of bubble insertion after a halt request before entering HALTED (must be >=1).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- ifid_rs1  input  5  rs1 field of the instruction in IF/ID.
- ifid_rs2  input  5  rs2 field of the instruction in IF/ID.
- ifid_uses_rs1  input  1  ID instruction reads rs1.
- ifid_uses_rs2  input  1  ID instruction reads rs2.
- idex_rd  input  5  destination register held in ID/EX.
- idex_mem_read  input  1  ID/EX holds a load.
- pc_src  input  1  taken branch from EX/MEM (branch_d3 & alu_zero_d3).
- mem_busy  input  1  data memory not ready this cycle.
- halt_req  input  1  ID instruction is ecall/ebreak.
- PC_write  output  1  PC update enable.
- ifid_write  output  1  IF/ID load enable.
- ctrl_hazard  output  1  zero the ID control signals (bubble into ID/EX).
- flush_ifid  output  1  clear IF/ID on next edge.
- flush_idex  output  1  clear ID/EX on next edge.
- flush_exmem  output  1  clear EX/MEM on next edge.
- pipe_en  output  1  load enable for ID/EX, EX/MEM and MEM/WB.
- halted  output  1  core halted.
- stall_count  output  CNT_W  stall cycles (load-use + freeze).
- flush_count  output  CNT_W  branch flush events.

Behaviour:
- FSM states: RUN, DRAIN, HALTED. Drain counter width is clog2(DRAIN_CYCLES)+1. Counters and state are the only flops; all other outputs are combinational from state and inputs.
- rst=1, asynchronous: state=RUN, drain counter=0, both counters=0. While rst is high, outputs are forced: PC_write=0, ifid_write=0, pipe_en=0, ctrl_hazard=1, all flushes=0, halted=0.
- Load-use hazard: lu = idex_mem_read & (idex_rd!=0) & ((ifid_uses_rs1 & ifid_rs1==idex_rd) | (ifid_uses_rs2 & ifid_rs2==idex_rd)). An rd of x0 never stalls.
- Per-cycle priority in RUN/DRAIN: mem_busy > pc_src > halt_req/DRAIN > lu > normal.
- Normal (RUN): PC_write=1, ifid_write=1, pipe_en=1, ctrl_hazard=0, flushes=0.
- Freeze (mem_busy=1, RUN or DRAIN): PC_write=0, ifid_write=0, pipe_en=0, ctrl_hazard=0, flushes=0. stall_count+1. State and drain counter hold; pc_src and lu are ignored this cycle and re-evaluated after release.
- Flush (pc_src=1, not frozen):
  - flush_ifid=flush_idex=flush_exmem=1; PC_write=1; ifid_write=1; pipe_en=1; ctrl_hazard=0.
  - flush_count+1; lu and halt_req are ignored.
  - If in DRAIN: state returns to RUN, because the halting instruction was younger and is flushed.
- Halt entry (RUN, halt_req=1, no freeze/flush): PC_write=0, ifid_write=0, ctrl_hazard=1, pipe_en=1. Next state=DRAIN, drain counter loads DRAIN_CYCLES-1.
- DRAIN (not frozen, no flush): PC_write=0, ifid_write=0, ctrl_hazard=1, pipe_en=1. Counter decrements each cycle; at 0 it goes to HALTED on the next edge. DRAIN therefore lasts exactly DRAIN_CYCLES unfrozen cycles after the entry cycle. lu is irrelevant.
- Load-use stall (RUN, lu=1, no freeze/flush/halt): PC_write=0, ifid_write=0, ctrl_hazard=1, pipe_en=1, stall_count+1. Lasts exactly one cycle in practice, since the bubble clears idex_mem_read.
- HALTED: PC_write=0, ifid_write=0, pipe_en=0, ctrl_hazard=1, flushes=0, halted=1. All inputs are ignored; the only exit is rst.
- Counters increment at the clock edge and saturate at 2^CNT_W-1 with no wrap.
- pc_src and lu in the same cycle: flush wins; no stall is counted.

Test Plan:
- Load-use: idex_mem_read=1, idex_rd=5, ifid_rs2=5, ifid_uses_rs2=1 for one cycle -> PC_write=0, ifid_write=0, ctrl_hazard=1 that cycle; stall_count 0->1; next cycle with idex_mem_read=0, all enables=1.
- x0 and unused operand: idex_rd=0 with matching rs1, or ifid_uses_rs2=0 with rs2==rd=7 -> no stall, stall_count stays 0.
- Branch flush with concurrent hazard: pc_src=1 and lu=1 -> three flushes=1, PC_write=1, ctrl_hazard=0; flush_count=1, stall_count=0.
- Freeze: mem_busy=1 for 3 cycles while pc_src=1 -> pipe_en=0, PC_write=0, flushes=0 for 3 cycles; stall_count=3; on release, flush asserted for 1 cycle.
- Halt with DRAIN_CYCLES=4: halt_req pulse -> entry cycle plus 4 DRAIN cycles with ctrl_hazard=1, then halted=1, pipe_en=0. A mem_busy cycle mid-drain extends the drain by 1. pc_src=1 during DRAIN -> back to RUN, halted stays 0.
- Reset mid-DRAIN and in HALTED: assert rst asynchronously -> outputs forced to reset values immediately, halted=0, counters=0; RUN behaviour resumes after deassertion.
